// File: rtl/sd_controller_pkg.sv
// Shared AXI constants, chunk geometry and the reader FSM state type for the SD controller.
package sd_controller_pkg;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [31:0] CHUNK_BYTES = 32'd1024;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData,
    StFinish
  } sd_axi_reader_state_t;

endpackage

// File: rtl/sd_controller_axi_reader.sv
// AXI4 read master: fetches one 1024-byte chunk into the ping-pong buffer write port.
// Optional watchdog enabled by defining SD_AXI_READER_TIMEOUT_EN.
module sd_controller_axi_reader
  import sd_controller_pkg::*;
#(
  parameter int unsigned BUF_ADDR_WIDTH = 8,
  parameter int unsigned BURST_BEATS    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic [31:0]               axi_araddr,
  output logic [2:0]                axi_arprot,
  output logic [1:0]                axi_arburst,
  output logic [7:0]                axi_arlen,
  output logic [2:0]                axi_arsize,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [31:0]               axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  output logic [BUF_ADDR_WIDTH-1:0] buffer_addr,
  output logic [31:0]               buffer_data,
  output logic                      buffer_we,
  input  logic [31:0]               initial_addr,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned NUM_BURSTS = (2 ** BUF_ADDR_WIDTH) / BURST_BEATS;

  sd_axi_reader_state_t      state;
  logic [31:0]               base;
  logic [BUF_ADDR_WIDTH-1:0] burst_idx;
  logic [8:0]                beat;
  logic                      armed;

  logic [31:0] burst_ext, beat_ext, word_idx, next_araddr, start_base;
  logic        last_beat, last_burst, bad_rlast;

  assign axi_arprot  = 3'b000;
  assign axi_arburst = BURST_INCR;
  assign axi_arlen   = 8'(BURST_BEATS - 1);
  assign axi_arsize  = SIZE_4B;

  assign burst_ext   = 32'(burst_idx);
  assign beat_ext    = 32'(beat);
  assign word_idx    = burst_ext * BURST_BEATS + beat_ext;
  assign last_beat   = (beat_ext == BURST_BEATS - 1);
  assign last_burst  = (burst_ext == NUM_BURSTS - 1);
  assign next_araddr = base + (burst_ext + 32'd1) * (BURST_BEATS * 4);
  assign start_base  = initial_addr & ~(CHUNK_BYTES - 32'd1);
  // Burst length is counted locally; rlast only cross-checks the slave.
  assign bad_rlast   = (axi_rlast != last_beat);

`ifdef SD_AXI_READER_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= StIdle;
      base        <= '0;
      burst_idx   <= '0;
      beat        <= '0;
      armed       <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_rready  <= 1'b0;
      buffer_we   <= 1'b0;
      buffer_addr <= '0;
      buffer_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef SD_AXI_READER_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      // Swallows a start that coincides with reset release.
      armed     <= 1'b1;
      buffer_we <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && armed) begin
            base        <= start_base;
            axi_araddr  <= start_base;
            burst_idx   <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            axi_arvalid <= 1'b1;
            state       <= StAddr;
          end
        end
        StAddr: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            beat        <= '0;
            state       <= StData;
          end
        end
        StData: begin
          if (axi_rvalid) begin
            buffer_we   <= 1'b1;
            buffer_addr <= word_idx[BUF_ADDR_WIDTH-1:0];
            buffer_data <= axi_rdata;
            beat        <= beat + 9'd1;
            if (axi_rresp[1] || bad_rlast) err <= 1'b1;
            if (last_beat) begin
              axi_rready <= 1'b0;
              if (last_burst) begin
                done  <= 1'b1;
                state <= StFinish;
              end else begin
                burst_idx   <= burst_idx + 1'b1;
                axi_araddr  <= next_araddr;
                axi_arvalid <= 1'b1;
                state       <= StAddr;
              end
            end
          end
        end
        StFinish: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
`ifdef SD_AXI_READER_TIMEOUT_EN
      if ((state == StAddr && !axi_arready) || (state == StData && !axi_rvalid)) begin
        if (wd_cnt == TIMEOUT_CYCLES - 1) begin
          wd_cnt      <= '0;
          err         <= 1'b1;
          axi_arvalid <= 1'b0;
          axi_rready  <= 1'b0;
          done        <= 1'b1;
          state       <= StFinish;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule
